// File: rtl/mem_access_unit.sv
// Memory-stage access unit: turns EX/MEM load/store requests into an ack-handshaked
// doubleword memory transaction, stalling the pipeline. Option macro: MAU_MISALIGN_CHECK_EN.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [63:0] AluOut_in,
  input  logic [63:0] WriteData,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic [4:0]  Rd_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack,
  output logic [63:0] Dataout_Memory,
  output logic [63:0] AluOut,
  output logic        RegWrite_Out,
  output logic        MemtoReg_Out,
  output logic [4:0]  Rd_out,
  output logic        stall,
  output logic        misalign_err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state;
  logic        access;
  logic        blocked;
  logic        start;
  logic [2:0]  offset;
  logic [1:0]  size;
  logic [2:0]  off_p0;
  logic [1:0]  size_p0;
  logic        zext_p0;

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

  // Doubleword accesses ignore funct3[2], so 111 behaves exactly like 011.
  function automatic logic [63:0] load_extend(input logic [63:0] lane,
                                              input logic [1:0]  sz,
                                              input logic        zext);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    b = lane[7:0];
    h = lane[15:0];
    w = lane[31:0];
    case (sz)
      2'b00:   load_extend = zext ? {56'd0, lane[7:0]}  : 64'(b);
      2'b01:   load_extend = zext ? {48'd0, lane[15:0]} : 64'(h);
      2'b10:   load_extend = zext ? {32'd0, lane[31:0]} : 64'(w);
      default: load_extend = lane;
    endcase
  endfunction

  assign access = MemRead | MemWrite;
  assign offset = AluOut_in[2:0];
  assign size   = funct3[1:0];

`ifdef MAU_MISALIGN_CHECK_EN
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] off);
    case (sz)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = off[0];
      2'b10:   is_misaligned = |off[1:0];
      default: is_misaligned = |off;
    endcase
  endfunction

  assign blocked      = access && is_misaligned(size, offset);
  assign misalign_err = !reset && (state == IDLE) && blocked;
`else
  assign blocked      = 1'b0;
  assign misalign_err = 1'b0;
`endif

  assign start = (state == IDLE) && access && !blocked;
  assign stall = (state == WAIT) || start;

  assign AluOut       = AluOut_in;
  assign Rd_out       = Rd_in;
  assign RegWrite_Out = RegWrite && !stall && !misalign_err;
  assign MemtoReg_Out = MemtoReg && !stall && !misalign_err;

  // Stage p0: request issue (IDLE) and completion/load capture (WAIT -> DONE)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_wstrb      <= '0;
      Dataout_Memory <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= WAIT;
            mem_req   <= 1'b1;
            mem_we    <= MemWrite;
            mem_addr  <= {AluOut_in[63:3], 3'b000};
            mem_wstrb <= size_mask(size) << offset;
            mem_wdata <= MemWrite ? (WriteData << {offset, 3'b000}) : 64'd0;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
            if (!mem_we)
              Dataout_Memory <= load_extend(mem_rdata >> {off_p0, 3'b000}, size_p0, zext_p0);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Lane/extension controls are pure data, held from issue until the ack
  always_ff @(posedge clk) begin
    if (start) begin
      off_p0  <= offset;
      size_p0 <= size;
      zext_p0 <= funct3[2];
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL use one clock and one reset: clock `clk`, reset `reset`, asynchronous, active-high.
REQ-002 Ports, in order (name, direction, width, meaning):
- `clk`: in, 1, rising-edge clock.
- `reset`: in, 1, async active-high reset.
- `MemRead`: in, 1, load request from EX/MEM.
- `MemWrite`: in, 1, store request from EX/MEM.
- `funct3`: in, 3, access size/sign.
- `AluOut_in`: in, 64, effective address.
- `WriteData`: in, 64, store data (rs2).
- `RegWrite`: in, 1, control pass-through.
- `MemtoReg`: in, 1, control pass-through.
- `Rd_in`: in, 5, destination register.
- `mem_req`: out, 1, memory request, registered.
- `mem_we`: out, 1, 1 = write.
- `mem_addr`: out, 64, doubleword-aligned address.
- `mem_wdata`: out, 64, lane-positioned store data.
- `mem_wstrb`: out, 8, byte enables.
- `mem_rdata`: in, 64, read doubleword.
- `mem_ack`: in, 1, one-cycle completion.
- `Dataout_Memory`: out, 64, extended load data to MEM_WB.
- `AluOut`: out, 64, `AluOut_in` passed through combinationally.
- `RegWrite_Out`: out, 1, gated RegWrite.
- `MemtoReg_Out`: out, 1, gated MemtoReg.
- `Rd_out`: out, 5, `Rd_in` passed through.
- `stall`: out, 1, freezes PC/IF/ID/EX/MEM.
- `misalign_err`: out, 1, misaligned-access flag (see REQ-018).

Function
REQ-003 FSM SHALL have three states: IDLE, WAIT, DONE.
REQ-004 In IDLE, an access (`MemRead` or `MemWrite`) SHALL assert `stall` combinationally the same cycle. The unit SHALL latch address, size, data and direction, and enter WAIT at the next edge with `mem_req`=1.
REQ-005 In WAIT, `mem_req` SHALL stay 1 and the latched request SHALL stay stable until `mem_ack` is sampled high. At that edge the FSM SHALL enter DONE, `mem_req` SHALL drop, and load data SHALL be captured.
REQ-006 In DONE, `stall` SHALL be 0 for exactly one cycle. The FSM SHALL return to IDLE without starting a new access, even though EX/MEM still holds the same instruction.
REQ-007 `stall` SHALL be 1 in WAIT, and in IDLE when an access is present. Otherwise it SHALL be 0.
REQ-008 While `stall`=1, `RegWrite_Out` and `MemtoReg_Out` SHALL be 0 (bubble). Otherwise they SHALL equal their inputs.
REQ-009 `mem_addr` SHALL equal {addr[63:3],000}. The byte offset SHALL be addr[2:0].
REQ-010 Size decode from `funct3`[1:0]: 00 = byte, 01 = half, 10 = word, 11 = double. `funct3`[2]=1 SHALL select zero-extension; otherwise sign-extension. `funct3` 111 SHALL be treated as 011.
REQ-011 Store: `mem_wstrb` SHALL be the size mask shifted left by the offset. `mem_wdata` SHALL be `WriteData` shifted left by 8×offset.
REQ-012 Load: `mem_rdata` SHALL be shifted right by 8×offset, truncated to the size, extended per REQ-010, and registered into `Dataout_Memory`.
REQ-013 A store SHALL leave `Dataout_Memory` unchanged.
REQ-014 With `MemRead` and `MemWrite` both 1, the unit SHALL perform the store only.
REQ-015 A `mem_ack` arriving outside WAIT SHALL be ignored.
REQ-016 With no access, the unit SHALL add zero latency: the instruction passes in the same cycle. Minimum access latency SHALL be 2 stall cycles (ack on first WAIT cycle), then one DONE cycle.

Reset
REQ-017 Reset SHALL force, immediately and at any state including WAIT: FSM = IDLE, `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `mem_wstrb` = 0, `Dataout_Memory` = 0, `misalign_err` = 0. A pending access SHALL be abandoned, and an ack following reset SHALL be ignored.

Configuration
REQ-018 Macro `MAU_MISALIGN_CHECK_EN` controls misalignment checking.
- Defined: an access whose offset is not a multiple of its size SHALL issue no memory request and SHALL not stall. `misalign_err` SHALL pulse 1 for that cycle, and `RegWrite_Out` and `MemtoReg_Out` SHALL be 0.
- Undefined: `misalign_err` SHALL be tied to 0. Offset SHALL be used as-is, and bytes shifted beyond lane 7 SHALL be dropped.

Verification
REQ-019 Run the following directed scenarios:
- LB, addr 0x1003, `mem_rdata` 0x0000_0000_8000_0000, ack on first WAIT cycle -> `mem_addr` 0x1000, `stall` high for 2 cycles, `Dataout_Memory` 0xFFFF_FFFF_FFFF_FF80.
- SH, addr 0x2006, `WriteData` 0x1234 -> `mem_wstrb` 0xC0, `mem_wdata` 0x1234_0000_0000_0000, `mem_we`=1, `Dataout_Memory` unchanged.
- LWU, addr 0x10, `mem_rdata` 0x0000_0000_F000_0001, ack delayed 5 cycles -> `stall` high for 6 cycles, `Dataout_Memory` 0x0000_0000_F000_0001, `RegWrite_Out`=0 while stalled.
- Reset asserted in WAIT, then a stray `mem_ack` -> `mem_req`=0 immediately, FSM in IDLE, no DONE cycle, `Dataout_Memory`=0.
- With `MAU_MISALIGN_CHECK_EN`: LD, addr 0x4004 -> `mem_req` stays 0, `misalign_err`=1 for one cycle, `stall`=0. Without the macro: LD proceeds with `mem_wstrb`/extraction per REQ-018.
